branch_predictor_btb: RTL and testbench

Parametrised branch target buffer with saturating-counter direction predictor. It replaces the pipeline's fixed predict-not-taken fetch with a lookup in IF. It is trained by the stage that resolves branches and jumps (MEM), and that stage also receives the redirect/flush decision from it. Lookup is combinational against pc; the table and statistics update synchronously on clock.

---
 rtl/branch_predictor_btb_pkg.sv | 34 +++
 rtl/branch_predictor_btb_sat_counter.sv | 27 ++
 rtl/branch_predictor_btb.sv | 121 ++++++++++++
 tb/tb_branch_predictor_btb.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_btb_pkg.sv
// Shared BTB types: table entry layout, index/tag slicing, counter constants.
// No logic of its own; widths here set the entry storage format.
// Consumers must instantiate with widths matching these constants.
package bp_pkg;

    localparam int BP_XLEN  = 32;
    localparam int BP_TAG_W = 8;
    localparam int BP_CTR_W = 2;

    // Saturation ceiling and the "weakly taken" value given to fresh allocations.
    localparam logic [BP_CTR_W-1:0] CTR_MAX    = '1;
    localparam logic [BP_CTR_W-1:0] CTR_WEAK_T = BP_CTR_W'(1 << (BP_CTR_W - 1));

    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic                is_jump;
        logic [BP_CTR_W-1:0] ctr;
        logic [BP_XLEN-1:0]  target;
    } bp_entry_t;

    // Word index into the table: pc[idx_w+1:2], returned zero-extended.
    function automatic logic [BP_XLEN-1:0] bp_index(input logic [BP_XLEN-1:0] pc,
                                                     input int unsigned idx_w);
        return (pc >> 2) & ((BP_XLEN'(1) << idx_w) - BP_XLEN'(1));
    endfunction

    // Tag bits sitting directly above the index bits.
    function automatic logic [BP_TAG_W-1:0] bp_tag(input logic [BP_XLEN-1:0] pc,
                                                    input int unsigned idx_w);
        return BP_TAG_W'(pc >> (idx_w + 2));
    endfunction

endpackage

// File: rtl/branch_predictor_btb_sat_counter.sv
// Saturating up/down counter next-value logic with priority load.
// Latency: purely combinational; the caller owns the state register.
// Backpressure: none; holds at 0 and all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 2
) (
    input  logic [W-1:0] cnt_i,
    input  logic         inc_i,
    input  logic         dec_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] cnt_o
);

    // Load wins; otherwise step one toward the requested end unless already there.
    always_comb begin
        cnt_o = cnt_i;
        if (load_i) begin
            cnt_o = load_val_i;
        end else if (inc_i && (cnt_i != {W{1'b1}})) begin
            cnt_o = cnt_i + W'(1);
        end else if (dec_i && (cnt_i != {W{1'b0}})) begin
            cnt_o = cnt_i - W'(1);
        end
    end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB plus per-entry saturating direction counter, trained from MEM.
// Latency: lookup and mispredict are combinational; table/stats update at the next clock.
// Backpressure: none; one resolved update is accepted every cycle, reset drops it.
module branch_predictor_btb
    import bp_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 64,
    parameter int TAG_W    = 8,
    parameter int CTR_W    = 2,
    parameter int CTR_INIT = 1,
    parameter int STAT_W   = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [XLEN-1:0]   pc_if,
    output logic              pred_taken,
    output logic [XLEN-1:0]   pred_target,
    input  logic              upd_valid,
    input  logic [XLEN-1:0]   upd_pc,
    input  logic              upd_is_jump,
    input  logic              upd_taken,
    input  logic [XLEN-1:0]   upd_target,
    input  logic              upd_pred_taken,
    input  logic [XLEN-1:0]   upd_pred_target,
    output logic              mispredict,
    output logic [XLEN-1:0]   redirect_pc,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [BP_CTR_W-1:0] CTR_RST  = BP_CTR_W'(CTR_INIT);
    localparam logic [STAT_W-1:0]   STAT_MAX = '1;

    // Entry storage format is fixed by the package; reject mismatched builds.
    if (XLEN != BP_XLEN || TAG_W != BP_TAG_W || CTR_W != BP_CTR_W || CTR_W < 2 ||
        ENTRIES != (1 << IDX_W) || (IDX_W + TAG_W + 2) > XLEN) begin : g_bad_cfg
        $error("branch_predictor_btb: parameters inconsistent with bp_pkg");
    end

    bp_entry_t          tbl_q [ENTRIES];
    bp_entry_t          tbl_d [ENTRIES];
    logic [STAT_W-1:0]  stat_br_q, stat_br_d;
    logic [STAT_W-1:0]  stat_mp_q, stat_mp_d;

    logic [IDX_W-1:0]    lk_idx, up_idx;
    bp_entry_t           lk_ent, up_ent;
    logic                lk_hit, up_hit;
    logic [BP_CTR_W-1:0] ctr_nxt;

    // Fetch-side lookup: reads the registered table, so a same-cycle write is not seen.
    always_comb begin
        lk_idx      = IDX_W'(bp_index(pc_if, IDX_W));
        lk_ent      = tbl_q[lk_idx];
        lk_hit      = lk_ent.valid && (lk_ent.tag == bp_tag(pc_if, IDX_W));
        pred_taken  = lk_hit && (lk_ent.is_jump || lk_ent.ctr[BP_CTR_W-1]);
        pred_target = pred_taken ? lk_ent.target : pc_if + XLEN'(4);
    end

    // Resolution side: compare actual outcome with what fetch assumed.
    always_comb begin
        mispredict  = upd_valid && ((upd_taken != upd_pred_taken) ||
                                    (upd_taken && (upd_target != upd_pred_target)));
        redirect_pc = upd_taken ? upd_target : upd_pc + XLEN'(4);
        up_idx      = IDX_W'(bp_index(upd_pc, IDX_W));
        up_ent      = tbl_q[up_idx];
        up_hit      = up_ent.valid && (up_ent.tag == bp_tag(upd_pc, IDX_W));
    end

    // Single shared counter step: trains branches on hit, seeds weakly-taken on allocate.
    sat_counter #(.W(BP_CTR_W)) u_ctr (
        .cnt_i      (up_ent.ctr),
        .inc_i      (up_hit && !upd_is_jump && upd_taken),
        .dec_i      (up_hit && !upd_is_jump && !upd_taken),
        .load_i     (!up_hit),
        .load_val_i (CTR_WEAK_T),
        .cnt_o      (ctr_nxt)
    );

    // Next table contents and saturating statistics.
    always_comb begin
        tbl_d     = tbl_q;
        stat_br_d = stat_br_q;
        stat_mp_d = stat_mp_q;
        if (upd_valid) begin
            if (stat_br_q != STAT_MAX) stat_br_d = stat_br_q + STAT_W'(1);
            if (mispredict && (stat_mp_q != STAT_MAX)) stat_mp_d = stat_mp_q + STAT_W'(1);
            if (up_hit) begin
                tbl_d[up_idx].ctr     = ctr_nxt;
                tbl_d[up_idx].is_jump = upd_is_jump;
                if (upd_taken) tbl_d[up_idx].target = upd_target;
            end else if (upd_taken) begin
                tbl_d[up_idx] = '{valid:   1'b1,
                                  tag:     bp_tag(upd_pc, IDX_W),
                                  is_jump: upd_is_jump,
                                  ctr:     ctr_nxt,
                                  target:  upd_target};
            end
        end
    end

    // State registers; reset clears every entry in one cycle and drops the update.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_q[i] <= '{valid: 1'b0, tag: '0, is_jump: 1'b0, ctr: CTR_RST, target: '0};
            end
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            tbl_q     <= tbl_d;
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed plan steps followed by randomized traffic against a behavioural BTB model.
// Inputs change 1ns after the rising edge; outputs are compared before the next edge.
// Statistics are built 4 bits wide so saturation is reached quickly.
module tb_branch_predictor_btb;

    localparam int NENT = 64;
    localparam int SMAX = 15;
    localparam int CMAX = 3;

    logic        clock;
    logic        reset;
    logic [31:0] pc_if;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_is_jump;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [3:0]  stat_branches;
    logic [3:0]  stat_mispredicts;

    int total = 0;
    int bad   = 0;

    branch_predictor_btb #(.STAT_W(4)) dut (
        .clock            (clock),
        .reset            (reset),
        .pc_if            (pc_if),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_is_jump      (upd_is_jump),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_pred_taken   (upd_pred_taken),
        .upd_pred_target  (upd_pred_target),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural model: one record per table slot, counters as plain integers.
    bit          m_v   [NENT];
    bit [7:0]    m_tag [NENT];
    bit          m_j   [NENT];
    int          m_ctr [NENT];
    bit [31:0]   m_tgt [NENT];
    int          m_br = 0;
    int          m_mp = 0;
    bit          model_ok = 0;

    function automatic int slot(input logic [31:0] pc);
        return int'((pc / 4) % NENT);
    endfunction

    function automatic bit [7:0] tagof(input logic [31:0] pc);
        return 8'((pc / (4 * NENT)) % 256);
    endfunction

    task automatic m_pred(input logic [31:0] pc, output logic tk, output logic [31:0] tg);
        int  i;
        bit  hit;
        i   = slot(pc);
        hit = m_v[i] && (m_tag[i] == tagof(pc));
        tk  = hit && (m_j[i] || (m_ctr[i] >= 2));
        tg  = tk ? m_tgt[i] : pc + 32'd4;
    endtask

    task automatic m_reset();
        for (int i = 0; i < NENT; i++) begin
            m_v[i] = 0; m_tag[i] = 0; m_j[i] = 0; m_ctr[i] = 1; m_tgt[i] = 0;
        end
        m_br = 0; m_mp = 0; model_ok = 1;
    endtask

    task automatic m_update(input logic [31:0] pc, input logic isj, input logic tk,
                            input logic [31:0] tg, input logic mp);
        int i;
        bit hit;
        i   = slot(pc);
        hit = m_v[i] && (m_tag[i] == tagof(pc));
        if (m_br < SMAX) m_br++;
        if (mp && m_mp < SMAX) m_mp++;
        if (hit) begin
            if (!isj) m_ctr[i] = tk ? ((m_ctr[i] < CMAX) ? m_ctr[i] + 1 : CMAX)
                                    : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
            if (tk) m_tgt[i] = tg;
            m_j[i] = isj;
        end else if (tk) begin
            m_v[i] = 1; m_tag[i] = tagof(pc); m_j[i] = isj; m_ctr[i] = 2; m_tgt[i] = tg;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output with the model, then clock once and advance the model.
    task automatic cyc();
        logic        mt, emp, v, j, tk;
        logic [31:0] mtg, erd, p, t;
        #1;
        emp = upd_valid && ((upd_taken != upd_pred_taken) ||
                            (upd_taken && (upd_target != upd_pred_target)));
        erd = upd_taken ? upd_target : upd_pc + 32'd4;
        chk("mispredict", mispredict, emp);
        chk("redirect_pc", redirect_pc, erd);
        if (model_ok && !reset) begin
            m_pred(pc_if, mt, mtg);
            chk("pred_taken", pred_taken, mt);
            chk("pred_target", pred_target, mtg);
            chk("stat_branches", stat_branches, m_br);
            chk("stat_mispredicts", stat_mispredicts, m_mp);
        end
        v = upd_valid; p = upd_pc; j = upd_is_jump; tk = upd_taken; t = upd_target;
        @(posedge clock);
        if (reset) m_reset();
        else if (v) m_update(p, j, tk, t, emp);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic isj, input logic tk,
                       input logic [31:0] tg, input logic ptk, input logic [31:0] ptg);
        upd_valid = 1; upd_pc = pc; upd_is_jump = isj; upd_taken = tk;
        upd_target = tg; upd_pred_taken = ptk; upd_pred_target = ptg;
    endtask

    task automatic idle();
        upd_valid = 0;
    endtask

    initial begin
        logic        rtk;
        logic [31:0] rtg, rpc;
        reset = 1; pc_if = 32'h40;
        upd_valid = 0; upd_pc = 0; upd_is_jump = 0; upd_taken = 0;
        upd_target = 0; upd_pred_taken = 0; upd_pred_target = 0;
        #1;
        cyc(); cyc();
        reset = 0;

        // Post-reset lookup misses.
        #1;
        chk("rst_pred_taken", pred_taken, 0);
        chk("rst_pred_target", pred_target, 32'h44);
        chk("rst_stat_br", stat_branches, 0);
        chk("rst_stat_mp", stat_mispredicts, 0);
        cyc();

        // Taken branch 0x40 -> 0x10, predicted not-taken.
        upd(32'h40, 0, 1, 32'h10, 0, 32'h44);
        #1;
        chk("b1_mispredict", mispredict, 1);
        chk("b1_redirect", redirect_pc, 32'h10);
        cyc();
        idle(); #1;
        chk("b1_pred_taken", pred_taken, 1);
        chk("b1_pred_target", pred_target, 32'h10);
        chk("b1_stat_mp", stat_mispredicts, 1);
        cyc();

        // Not-taken twice: counter 2 -> 1 -> 0, then holds.
        upd(32'h40, 0, 0, 32'h10, 1, 32'h10);
        #1;
        chk("nt1_redirect", redirect_pc, 32'h44);
        cyc();
        idle(); #1;
        chk("nt1_pred_taken", pred_taken, 0);
        cyc();
        upd(32'h40, 0, 0, 32'h10, 0, 32'h44);
        #1;
        chk("nt2_mispredict", mispredict, 0);
        cyc();
        upd(32'h40, 0, 0, 32'h10, 0, 32'h44); cyc();
        upd(32'h40, 0, 1, 32'h10, 0, 32'h44); cyc();
        idle(); #1;
        chk("ctr_floor_pred", pred_taken, 0);
        cyc();

        // jal then jalr at 0x80; jump predicts taken even with counter at 0.
        pc_if = 32'h80;
        upd(32'h80, 1, 1, 32'h200, 0, 32'h84); cyc();
        upd(32'h80, 1, 1, 32'h300, 1, 32'h200);
        #1;
        chk("jalr_mispredict", mispredict, 1);
        chk("jalr_redirect", redirect_pc, 32'h300);
        cyc();
        idle(); #1;
        chk("jalr_pred_target", pred_target, 32'h300);
        cyc();
        upd(32'h80, 0, 0, 32'h0, 1, 32'h300); cyc();
        upd(32'h80, 0, 0, 32'h0, 0, 32'h84); cyc();
        upd(32'h80, 1, 1, 32'h300, 0, 32'h84); cyc();
        idle(); #1;
        chk("jump_ctr0_taken", pred_taken, 1);
        chk("jump_ctr0_target", pred_target, 32'h300);
        cyc();

        // Alias at 0x140 evicts 0x40.
        pc_if = 32'h40;
        upd(32'h40, 0, 1, 32'h10, 0, 32'h44); cyc();
        idle(); #1;
        chk("alias_pre_taken", pred_taken, 1);
        cyc();
        upd(32'h140, 0, 1, 32'h500, 0, 32'h144); cyc();
        idle(); #1;
        chk("alias_evict_taken", pred_taken, 0);
        chk("alias_evict_target", pred_target, 32'h44);
        cyc();

        // Same-cycle lookup/update sees old contents.
        pc_if = 32'h140;
        upd(32'h140, 0, 0, 32'h0, 1, 32'h500);
        #1;
        chk("same_cyc_taken", pred_taken, 1);
        chk("same_cyc_target", pred_target, 32'h500);
        cyc();
        idle(); #1;
        chk("after_wr_taken", pred_taken, 0);
        cyc();

        // Reset wins over a taken update.
        reset = 1; pc_if = 32'h40;
        upd(32'h40, 0, 1, 32'h10, 0, 32'h44); cyc();
        reset = 0; idle(); #1;
        chk("rst_upd_taken", pred_taken, 0);
        chk("rst_upd_stat_br", stat_branches, 0);
        cyc();

        // Statistics saturate at 15.
        for (int k = 0; k < 17; k++) begin
            upd(32'h1000, 0, 0, 32'h0, 1, 32'h2000);
            cyc();
        end
        idle(); #1;
        chk("sat_stat_br", stat_branches, 15);
        chk("sat_stat_mp", stat_mispredicts, 15);
        cyc();

        // Randomized traffic with frequent aliasing and occasional reset.
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 39) == 0);
            rpc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
            if ($urandom_range(0, 15) == 0) rpc = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 31) == 0) rpc = 32'hFFFF_FFFC;
            pc_if = $urandom_range(0, 1) ? rpc
                  : ((32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2));
            upd_valid   = ($urandom_range(0, 3) != 0);
            upd_pc      = rpc;
            upd_is_jump = ($urandom_range(0, 3) == 0);
            upd_taken   = upd_is_jump | $urandom_range(0, 1);
            upd_target  = $urandom_range(0, 3) ? (32'($urandom_range(0, 7)) << 4)
                                               : ($urandom & 32'hFFFF_FFFE);
            m_pred(rpc, rtk, rtg);
            if ($urandom_range(0, 3) != 0) begin
                upd_pred_taken = rtk; upd_pred_target = rtg;
            end else begin
                upd_pred_taken = $urandom_range(0, 1); upd_pred_target = $urandom & 32'hFFFF_FFFC;
            end
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
